// File: rtl/exe_stage_module.sv
// Execute stage of the ARM pipeline: second-operand generation, ALU, NZCV
// status register, branch-target adder and the EXE/MEM pipeline register.
module exe_stage_module #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              s_in,
  input  logic              imm,
  input  logic              b_in,
  input  logic [3:0]        exe_cmd,
  input  logic [11:0]       shift_operand,
  input  logic [23:0]       signed_imm_24,
  input  logic [WORD_W-1:0] pc_in,
  input  logic [WORD_W-1:0] val_Rn,
  input  logic [WORD_W-1:0] val_Rm,
  input  logic [ADDR_W-1:0] dest_in,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic [WORD_W-1:0] alu_res_out,
  output logic [WORD_W-1:0] val_Rm_out,
  output logic [ADDR_W-1:0] dest_out,
  output logic [3:0]        status_out,
  output logic              branch_taken,
  output logic [WORD_W-1:0] branch_addr,
  output logic              wb_en_hazard_out,
  output logic [ADDR_W-1:0] dest_hazard_out
);

  // ALU command encodings
  localparam logic [3:0] CmdMov = 4'b0001;
  localparam logic [3:0] CmdMvn = 4'b1001;
  localparam logic [3:0] CmdAdd = 4'b0010;
  localparam logic [3:0] CmdAdc = 4'b0011;
  localparam logic [3:0] CmdSub = 4'b0100;
  localparam logic [3:0] CmdSbc = 4'b0101;
  localparam logic [3:0] CmdAnd = 4'b0110;
  localparam logic [3:0] CmdOrr = 4'b0111;
  localparam logic [3:0] CmdEor = 4'b1000;

  // Shift types from shift_operand[6:5]
  localparam logic [1:0] ShLsl = 2'b00;
  localparam logic [1:0] ShLsr = 2'b01;
  localparam logic [1:0] ShAsr = 2'b10;

  // Rotate right; n == 0 works because a shift by WORD_W yields zero.
  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input logic [4:0] n);
    ror = (x >> n) | (x << (WORD_W - n));
  endfunction

  // State: EXE/MEM pipeline register and NZCV
  logic              wb_en_q, wb_en_d;
  logic              mem_r_en_q, mem_r_en_d;
  logic              mem_w_en_q, mem_w_en_d;
  logic [WORD_W-1:0] alu_res_q, alu_res_d;
  logic [WORD_W-1:0] val_rm_q, val_rm_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [3:0]        status_q, status_d;

  // Datapath
  logic [WORD_W-1:0] val2;
  logic [WORD_W-1:0] imm_ext;
  logic [4:0]        imm_rot;
  logic [4:0]        sh_amt;
  logic [1:0]        sh_type;
  logic [WORD_W-1:0] alu_res;
  logic [WORD_W:0]   arith_full;
  logic              c_in;
  logic              flag_n, flag_z, flag_c, flag_v;
  logic [WORD_W-1:0] br_off;

  assign imm_ext = {{(WORD_W-8){1'b0}}, shift_operand[7:0]};
  assign imm_rot = {shift_operand[11:8], 1'b0};
  assign sh_amt  = shift_operand[11:7];
  assign sh_type = shift_operand[6:5];
  assign c_in    = status_q[1];

  // Second operand: memory offset beats immediate beats register shift
  always_comb begin
    val2 = val_Rm;
    if (mem_r_en_in || mem_w_en_in) begin
      val2 = {{(WORD_W-12){1'b0}}, shift_operand};
    end else if (imm) begin
      val2 = ror(imm_ext, imm_rot);
    end else begin
      case (sh_type)
        ShLsl:   val2 = val_Rm << sh_amt;
        ShLsr:   val2 = val_Rm >> sh_amt;
        ShAsr:   val2 = $unsigned($signed(val_Rm) >>> sh_amt);
        default: val2 = ror(val_Rm, sh_amt);
      endcase
    end
  end

  // ALU result plus C/V; logical ops and unknown commands keep the old C/V
  always_comb begin
    alu_res    = '0;
    arith_full = '0;
    flag_c     = status_q[1];
    flag_v     = status_q[0];
    case (exe_cmd)
      CmdMov: alu_res = val2;
      CmdMvn: alu_res = ~val2;
      CmdAdd, CmdAdc: begin
        arith_full = {1'b0, val_Rn} + {1'b0, val2}
                   + {{WORD_W{1'b0}}, (exe_cmd == CmdAdc) & c_in};
        alu_res    = arith_full[WORD_W-1:0];
        flag_c     = arith_full[WORD_W];
        flag_v     = (val_Rn[WORD_W-1] == val2[WORD_W-1]) &&
                     (alu_res[WORD_W-1] != val_Rn[WORD_W-1]);
      end
      CmdSub, CmdSbc: begin
        // Bit WORD_W of the 33-bit difference is the borrow; ARM C is its inverse.
        arith_full = {1'b0, val_Rn} - {1'b0, val2}
                   - {{WORD_W{1'b0}}, (exe_cmd == CmdSbc) & ~c_in};
        alu_res    = arith_full[WORD_W-1:0];
        flag_c     = ~arith_full[WORD_W];
        flag_v     = (val_Rn[WORD_W-1] != val2[WORD_W-1]) &&
                     (alu_res[WORD_W-1] != val_Rn[WORD_W-1]);
      end
      CmdAnd: alu_res = val_Rn & val2;
      CmdOrr: alu_res = val_Rn | val2;
      CmdEor: alu_res = val_Rn ^ val2;
      default: alu_res = '0;
    endcase
  end

  assign flag_n = alu_res[WORD_W-1];
  assign flag_z = (alu_res == '0);

  // Status update: freeze takes priority over s_in
  always_comb begin
    status_d = status_q;
    if (!freeze && s_in) begin
      status_d = {flag_n, flag_z, flag_c, flag_v};
    end
  end

  // Pipeline register next state: hold while frozen
  always_comb begin
    wb_en_d    = wb_en_q;
    mem_r_en_d = mem_r_en_q;
    mem_w_en_d = mem_w_en_q;
    alu_res_d  = alu_res_q;
    val_rm_d   = val_rm_q;
    dest_d     = dest_q;
    if (!freeze) begin
      wb_en_d    = wb_en_in;
      mem_r_en_d = mem_r_en_in;
      mem_w_en_d = mem_w_en_in;
      alu_res_d  = alu_res;
      val_rm_d   = val_Rm;
      dest_d     = dest_in;
    end
  end

  // EXE/MEM register and status register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      alu_res_q  <= '0;
      val_rm_q   <= '0;
      dest_q     <= '0;
      status_q   <= 4'b0000;
    end else begin
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      mem_w_en_q <= mem_w_en_d;
      alu_res_q  <= alu_res_d;
      val_rm_q   <= val_rm_d;
      dest_q     <= dest_d;
      status_q   <= status_d;
    end
  end

  // Branch target: word offset sign-extended and scaled by 4
  assign br_off      = {{(WORD_W-26){signed_imm_24[23]}}, signed_imm_24, 2'b00};
  assign branch_addr = pc_in + br_off;
  assign branch_taken = b_in;

  assign wb_en_hazard_out = wb_en_in;
  assign dest_hazard_out  = dest_in;

  assign wb_en_out    = wb_en_q;
  assign mem_r_en_out = mem_r_en_q;
  assign mem_w_en_out = mem_w_en_q;
  assign alu_res_out  = alu_res_q;
  assign val_Rm_out   = val_rm_q;
  assign dest_out     = dest_q;
  assign status_out   = status_q;

endmodule

// File: tb/tb_exe_stage_module.sv
// Self-checking bench for exe_stage_module: directed cases plus randomized
// traffic against a plain-arithmetic reference model.
module tb_exe_stage_module;

  logic        clk = 1'b0;
  logic        rst, freeze, wb_en_in, mem_r_en_in, mem_w_en_in, s_in, imm, b_in;
  logic [3:0]  exe_cmd;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [31:0] pc_in, val_Rn, val_Rm;
  logic [3:0]  dest_in;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out, branch_taken, wb_en_hazard_out;
  logic [31:0] alu_res_out, val_Rm_out, branch_addr;
  logic [3:0]  dest_out, status_out, dest_hazard_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        wb;
    logic        mr;
    logic        mw;
    logic [3:0]  dest;
    logic [31:0] alu;
    logic [31:0] rm;
    logic [3:0]  status;
  } obs_t;

  obs_t exp_q = '0;

  localparam longint SMax = 64'sd2147483647;
  localparam longint SMin = -64'sd2147483648;

  exe_stage_module #(.WORD_W(32), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .s_in(s_in), .imm(imm), .b_in(b_in), .exe_cmd(exe_cmd),
    .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
    .pc_in(pc_in), .val_Rn(val_Rn), .val_Rm(val_Rm), .dest_in(dest_in),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .alu_res_out(alu_res_out), .val_Rm_out(val_Rm_out), .dest_out(dest_out),
    .status_out(status_out), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .wb_en_hazard_out(wb_en_hazard_out), .dest_hazard_out(dest_hazard_out)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    return {wb_en_out, mem_r_en_out, mem_w_en_out, dest_out, alu_res_out, val_Rm_out,
            status_out};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_val2(logic mr, logic mw, logic im, logic [11:0] so,
                                         logic [31:0] rm);
    logic [31:0] v;
    int amt;
    if (mr || mw) return {20'd0, so};
    if (im) begin
      v = {24'd0, so[7:0]};
      for (int i = 0; i < 2 * int'(so[11:8]); i++) v = {v[0], v[31:1]};
      return v;
    end
    amt = int'(so[11:7]);
    case (so[6:5])
      2'd0: return rm << amt;
      2'd1: return rm >> amt;
      2'd2: return 32'($signed(rm) >>> amt);
      default: begin
        v = rm;
        for (int i = 0; i < amt; i++) v = {v[0], v[31:1]};
        return v;
      end
    endcase
  endfunction

  task automatic m_alu(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                       input logic [3:0] st, output logic [31:0] res, output logic [3:0] fl);
    longint ua, ub, sa, sb, t, s, cin;
    logic c, v;
    ua = longint'({32'd0, rn});
    ub = longint'({32'd0, v2});
    sa = longint'($signed(rn));
    sb = longint'($signed(v2));
    cin = longint'(st[1]);
    c = st[1];
    v = st[0];
    res = 32'd0;
    case (cmd)
      4'd1: res = v2;
      4'd9: res = ~v2;
      4'd2, 4'd3: begin
        if (cmd == 4'd2) cin = 0;
        t = ua + ub + cin;
        s = sa + sb + cin;
        res = 32'(t);
        c = (t > 64'sd4294967295);
        v = (s > SMax) || (s < SMin);
      end
      4'd4, 4'd5: begin
        t = (cmd == 4'd4) ? 0 : 1 - cin;
        res = 32'(ua - ub - t);
        c = (ua >= ub + t);
        s = sa - sb - t;
        v = (s > SMax) || (s < SMin);
      end
      4'd6: res = rn & v2;
      4'd7: res = rn | v2;
      4'd8: res = rn ^ v2;
      default: res = 32'd0;
    endcase
    fl = {res[31], res == 32'd0, c, v};
  endtask

  function automatic logic [31:0] m_branch(logic [31:0] pc, logic [23:0] off);
    int o;
    o = $signed(off);
    return pc + 32'(o * 4);
  endfunction

  // Model the coming clock edge from the current inputs, then step past it.
  task automatic advance();
    obs_t nxt;
    logic [31:0] v2, res;
    logic [3:0] fl;
    v2 = m_val2(mem_r_en_in, mem_w_en_in, imm, shift_operand, val_Rm);
    m_alu(exe_cmd, val_Rn, v2, exp_q.status, res, fl);
    nxt = exp_q;
    if (!freeze) begin
      nxt.wb = wb_en_in;
      nxt.mr = mem_r_en_in;
      nxt.mw = mem_w_en_in;
      nxt.dest = dest_in;
      nxt.alu = res;
      nxt.rm = val_Rm;
      if (s_in) nxt.status = fl;
    end
    @(posedge clk);
    #1;
    exp_q = rst ? '0 : nxt;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    freeze = 0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; s_in = 0; imm = 0; b_in = 0;
    exe_cmd = 0; shift_operand = 0; signed_imm_24 = 0; pc_in = 0; val_Rn = 0; val_Rm = 0;
    dest_in = 0;
  endtask

  function automatic logic [31:0] pick_word();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_random(input bit allow_freeze);
    wb_en_in      = 1'($urandom_range(0, 1));
    mem_r_en_in   = ($urandom_range(0, 7) == 0);
    mem_w_en_in   = ($urandom_range(0, 7) == 0);
    s_in          = 1'($urandom_range(0, 1));
    imm           = 1'($urandom_range(0, 1));
    b_in          = 1'($urandom_range(0, 1));
    exe_cmd       = 4'($urandom_range(0, 15));
    shift_operand = 12'($urandom);
    signed_imm_24 = 24'($urandom);
    pc_in         = $urandom;
    val_Rn        = pick_word();
    val_Rm        = pick_word();
    dest_in       = 4'($urandom);
    freeze        = allow_freeze && ($urandom_range(0, 4) == 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    rst = 0;
    #1 rst = 1;
    #1;
    n_checks++;
    if (observe() !== obs_t'('0)) begin
      n_fail++;
      $display("FAIL reset_async: got %h want %h", observe(), obs_t'('0));
    end
    drive_random(0);
    advance();
    n_checks++;
    if (observe() !== obs_t'('0)) begin
      n_fail++;
      $display("FAIL reset_held: got %h want %h", observe(), obs_t'('0));
    end
    rst = 0;
    clear_inputs();
  endtask

  task automatic test_add_overflow();
    clear_inputs();
    exe_cmd = 4'b0010; val_Rn = 32'h7FFF_FFFF; val_Rm = 32'd1; s_in = 1; wb_en_in = 1;
    dest_in = 4'd3;
    advance();
    n_checks++;
    if (alu_res_out !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL add_res: got %h want 80000000", alu_res_out);
    end
    n_checks++;
    if (status_out !== 4'b1001) begin
      n_fail++;
      $display("FAIL add_flags: got %b want 1001", status_out);
    end
    n_checks++;
    if (observe() !== exp_q) begin
      n_fail++;
      $display("FAIL add_all: got %h want %h", observe(), exp_q);
    end
  endtask

  task automatic test_sub_zero();
    clear_inputs();
    exe_cmd = 4'b0100; val_Rn = 32'd5; imm = 1; shift_operand = 12'h005; s_in = 1;
    advance();
    n_checks++;
    if (alu_res_out !== 32'd0) begin
      n_fail++;
      $display("FAIL sub_res: got %h want 00000000", alu_res_out);
    end
    n_checks++;
    if (status_out !== 4'b0110) begin
      n_fail++;
      $display("FAIL sub_flags: got %b want 0110", status_out);
    end
  endtask

  task automatic test_mov_imm();
    clear_inputs();
    exe_cmd = 4'b0001; imm = 1; shift_operand = 12'h4FF; s_in = 0;
    advance();
    n_checks++;
    if (alu_res_out !== 32'hFF00_0000) begin
      n_fail++;
      $display("FAIL mov_imm_res: got %h want ff000000", alu_res_out);
    end
    n_checks++;
    if (status_out !== 4'b0110) begin
      n_fail++;
      $display("FAIL mov_imm_flags: got %b want 0110", status_out);
    end
  endtask

  task automatic test_asr_ldr();
    clear_inputs();
    exe_cmd = 4'b0001; val_Rm = 32'h8000_0000; shift_operand = 12'h240;
    advance();
    n_checks++;
    if (alu_res_out !== 32'hF800_0000) begin
      n_fail++;
      $display("FAIL mov_asr: got %h want f8000000", alu_res_out);
    end
    clear_inputs();
    exe_cmd = 4'b0010; mem_r_en_in = 1; wb_en_in = 1; val_Rn = 32'h100; shift_operand = 12'h004;
    val_Rm = 32'hDEAD_BEEF; dest_in = 4'd7;
    advance();
    n_checks++;
    if (alu_res_out !== 32'h104) begin
      n_fail++;
      $display("FAIL ldr_addr: got %h want 00000104", alu_res_out);
    end
    n_checks++;
    if ({mem_r_en_out, mem_w_en_out, wb_en_out, dest_out} !== {1'b1, 1'b0, 1'b1, 4'd7}) begin
      n_fail++;
      $display("FAIL ldr_ctrl: got %b%b%b/%h want 101/7", mem_r_en_out, mem_w_en_out,
               wb_en_out, dest_out);
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    b_in = 1; pc_in = 32'h20; signed_imm_24 = 24'hFFFFFE; wb_en_in = 1; dest_in = 4'hA;
    #1;
    n_checks++;
    if ({branch_taken, branch_addr} !== {1'b1, 32'h18}) begin
      n_fail++;
      $display("FAIL branch: got %b/%h want 1/00000018", branch_taken, branch_addr);
    end
    n_checks++;
    if ({wb_en_hazard_out, dest_hazard_out} !== {1'b1, 4'hA}) begin
      n_fail++;
      $display("FAIL hazard_taps: got %b/%h want 1/a", wb_en_hazard_out, dest_hazard_out);
    end
    advance();
  endtask

  task automatic test_freeze_reset();
    obs_t held;
    clear_inputs();
    exe_cmd = 4'b0011; val_Rn = 32'hFFFF_FFFF; val_Rm = 32'd2; s_in = 1; wb_en_in = 1;
    mem_w_en_in = 1; dest_in = 4'd9;
    advance();
    held = exp_q;
    for (int i = 0; i < 3; i++) begin
      drive_random(0);
      freeze = 1;
      s_in = 1;
      #1;
      n_checks++;
      if (branch_addr !== m_branch(pc_in, signed_imm_24)) begin
        n_fail++;
        $display("FAIL freeze_comb: got %h want %h", branch_addr,
                 m_branch(pc_in, signed_imm_24));
      end
      advance();
      n_checks++;
      if (observe() !== held) begin
        n_fail++;
        $display("FAIL freeze_hold%0d: got %h want %h", i, observe(), held);
      end
    end
    #3 rst = 1;
    #1;
    n_checks++;
    if (observe() !== obs_t'('0)) begin
      n_fail++;
      $display("FAIL reset_mid_freeze: got %h want %h", observe(), obs_t'('0));
    end
    #1 rst = 0;
    exp_q = '0;
    clear_inputs();
    advance();
    n_checks++;
    if (observe() !== exp_q) begin
      n_fail++;
      $display("FAIL after_reset: got %h want %h", observe(), exp_q);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_random(1);
      #1;
      n_checks++;
      if ({branch_taken, branch_addr, wb_en_hazard_out, dest_hazard_out} !==
          {b_in, m_branch(pc_in, signed_imm_24), wb_en_in, dest_in}) begin
        n_fail++;
        $display("FAIL rand_comb%0d: got %b/%h want %b/%h", i, branch_taken, branch_addr,
                 b_in, m_branch(pc_in, signed_imm_24));
      end
      advance();
      n_checks++;
      if (observe() !== exp_q) begin
        n_fail++;
        $display("FAIL rand_reg%0d: got %h want %h", i, observe(), exp_q);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_zero();
    test_mov_imm();
    test_asr_ldr();
    test_branch();
    test_freeze_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
